// File: rtl/cover_counter_bank.sv
// Coverage and reset harness: sequences meta/DUT reset, counts true/false cycles per
// coverage point with saturation, latches the first assertion, and streams counts out.
module cover_counter_bank #(
  parameter int N_COVER      = 75,
  parameter int N_ASSERT     = 52,
  parameter int CNT_W        = 8,
  parameter int META_CYCLES  = 1,
  parameter int RESET_CYCLES = 1,
  localparam int IDX_W  = (N_COVER > 1) ? $clog2(N_COVER) : 1,
  localparam int AIDX_W = (N_ASSERT > 1) ? $clog2(N_ASSERT) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_COVER-1:0]  cover_in,
  input  logic [N_ASSERT-1:0] assert_in,
  input  logic                clear,
  input  logic                dump_start,
  output logic                meta_reset_out,
  output logic                dut_reset_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_index,
  output logic [CNT_W-1:0]    out_true_cnt,
  output logic [CNT_W-1:0]    out_false_cnt,
  output logic                out_last,
  output logic                assert_fired,
  output logic [AIDX_W-1:0]   assert_index,
  output logic                busy
);

  localparam logic [1:0] S_META = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DUMP = 2'd3;

  localparam int PH_MAX = (META_CYCLES > RESET_CYCLES) ? META_CYCLES : RESET_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0]  META_LAST = PH_W'(META_CYCLES - 1);
  localparam logic [PH_W-1:0]  RST_LAST  = PH_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_COVER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       state_reg, state_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  logic [N_COVER-1:0][CNT_W-1:0] true_cnt_reg, true_cnt_next;
  logic [N_COVER-1:0][CNT_W-1:0] false_cnt_reg, false_cnt_next;

  logic              fired_reg;
  logic [AIDX_W-1:0] fired_idx_reg;
  logic [AIDX_W-1:0] first_idx;
  logic              any_assert;
  logic              in_run;
  logic              clear_en;
  logic              fire_en;
  logic              count_en;

  assign in_run     = (state_reg == S_RUN);
  assign any_assert = |assert_in;
  assign clear_en   = in_run && clear;
  assign fire_en    = in_run && !clear && any_assert && !fired_reg;
  // Once an assertion has fired, stimulus is no longer meaningful: freeze until clear.
  assign count_en   = in_run && !clear && !any_assert && !fired_reg;

  always_comb begin
    first_idx = '0;
    for (int i = N_ASSERT - 1; i >= 0; i--) begin
      if (assert_in[i]) first_idx = AIDX_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_META: begin
        if (phase_reg == META_LAST) begin
          state_next = S_RST;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      S_RST: begin
        if (phase_reg == RST_LAST) begin
          state_next = S_RUN;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      S_RUN: begin
        if (dump_start && !clear) begin
          state_next = S_DUMP;
          idx_next   = '0;
        end
      end
      default: begin
        if (out_ready) begin
          if (idx_reg == IDX_LAST) begin
            state_next = S_RUN;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_META;
      phase_reg      <= '0;
      idx_reg        <= '0;
      meta_reset_out <= 1'b1;
      dut_reset_out  <= 1'b1;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      idx_reg        <= idx_next;
      meta_reset_out <= (state_next == S_META);
      dut_reset_out  <= (state_next == S_META) || (state_next == S_RST);
    end
  end

  for (genvar gi = 0; gi < N_COVER; gi++) begin : g_cnt
    assign true_cnt_next[gi] =
      clear_en ? '0 :
      (count_en && cover_in[gi] && (true_cnt_reg[gi] != CNT_MAX)) ?
        true_cnt_reg[gi] + CNT_W'(1) : true_cnt_reg[gi];
    assign false_cnt_next[gi] =
      clear_en ? '0 :
      (count_en && !cover_in[gi] && (false_cnt_reg[gi] != CNT_MAX)) ?
        false_cnt_reg[gi] + CNT_W'(1) : false_cnt_reg[gi];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      true_cnt_reg  <= '0;
      false_cnt_reg <= '0;
      fired_reg     <= 1'b0;
      fired_idx_reg <= '0;
    end else begin
      true_cnt_reg  <= true_cnt_next;
      false_cnt_reg <= false_cnt_next;
      if (clear_en) begin
        fired_reg     <= 1'b0;
        fired_idx_reg <= '0;
      end else if (fire_en) begin
        fired_reg     <= 1'b1;
        fired_idx_reg <= first_idx;
      end
    end
  end

  always_comb begin
    out_true_cnt  = '0;
    out_false_cnt = '0;
    for (int i = 0; i < N_COVER; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        out_true_cnt  = true_cnt_reg[i];
        out_false_cnt = false_cnt_reg[i];
      end
    end
  end

  // Decoded from the state register so an asynchronous reset drops the stream at once.
  assign out_valid    = (state_reg == S_DUMP);
  assign out_index    = idx_reg;
  assign out_last     = out_valid && (idx_reg == IDX_LAST);
  assign assert_fired = fired_reg;
  assign assert_index = fired_idx_reg;
  assign busy         = !in_run;

endmodule

// File: tb/tb_cover_counter_bank.sv
// Scoreboard bench for cover_counter_bank: stimulus pushes expected readout beats,
// a negedge monitor pops and checks every accepted beat and every stalled beat.
module tb_cover_counter_bank;

  logic       clock;
  logic       reset;
  logic [3:0] cover_in;
  logic [1:0] assert_in;
  logic       clear;
  logic       dump_start;
  logic       meta_reset_out;
  logic       dut_reset_out;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_index;
  logic [3:0] out_true_cnt;
  logic [3:0] out_false_cnt;
  logic       out_last;
  logic       assert_fired;
  logic [0:0] assert_index;
  logic       busy;

  cover_counter_bank #(
    .N_COVER(4), .N_ASSERT(2), .CNT_W(4), .META_CYCLES(2), .RESET_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .cover_in(cover_in), .assert_in(assert_in),
    .clear(clear), .dump_start(dump_start), .meta_reset_out(meta_reset_out),
    .dut_reset_out(dut_reset_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_true_cnt(out_true_cnt), .out_false_cnt(out_false_cnt),
    .out_last(out_last), .assert_fired(assert_fired), .assert_index(assert_index),
    .busy(busy)
  );

  typedef struct {
    logic [1:0] idx;
    logic [3:0] t;
    logic [3:0] f;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int tests = 0;
  int fails = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_beat(input int idx, input int t, input int f);
    beat_t b;
    b.idx  = 2'(idx);
    b.t    = 4'(t);
    b.f    = 4'(f);
    b.last = (idx == 3);
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 60; n++) begin
      if (!busy) break;
      step();
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_dump(input string name);
    dump_start = 1'b1;
    out_ready  = 1'b1;
    step();
    dump_start = 1'b0;
    wait_idle(name);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  // Monitor: compares every beat the DUT presents against the scoreboard head.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_beat: got idx=%0d with empty scoreboard", out_index);
      end else begin
        tests++;
        if (out_index !== exp_q[0].idx || out_true_cnt !== exp_q[0].t ||
            out_false_cnt !== exp_q[0].f || out_last !== exp_q[0].last) begin
          fails++;
          $display("[TB] FAIL %s: got idx=%0d t=%0d f=%0d last=%0d expected idx=%0d t=%0d f=%0d last=%0d",
                   out_ready ? "beat" : "stall_hold", out_index, out_true_cnt, out_false_cnt,
                   out_last, exp_q[0].idx, exp_q[0].t, exp_q[0].f, exp_q[0].last);
        end
        if (out_ready) begin
          $display("[TB] beat idx=%0d true=%0d false=%0d last=%0d",
                   out_index, out_true_cnt, out_false_cnt, out_last);
          void'(exp_q.pop_front());
        end else begin
          $display("[TB] stall idx=%0d true=%0d false=%0d", out_index, out_true_cnt, out_false_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    cover_in   = 4'b0101;
    assert_in  = 2'b00;
    clear      = 1'b0;
    dump_start = 1'b0;
    out_ready  = 1'b0;
    step();
    step();

    check("rst_meta", {31'd0, meta_reset_out}, 32'd1);
    check("rst_dut", {31'd0, dut_reset_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_index", {30'd0, out_index}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_cnts", {24'd0, out_true_cnt, out_false_cnt}, 32'd0);
    check("rst_assert", {30'd0, assert_fired, assert_index}, 32'd0);

    // Reset sequence: cycle k is the interval after edge k-1 (cycle 0 precedes edge 0).
    reset = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      check($sformatf("seq_meta_c%0d", k), {31'd0, meta_reset_out}, (k < 2) ? 32'd1 : 32'd0);
      check($sformatf("seq_dut_c%0d", k), {31'd0, dut_reset_out}, (k < 5) ? 32'd1 : 32'd0);
      check($sformatf("seq_busy_c%0d", k), {31'd0, busy}, (k < 5) ? 32'd1 : 32'd0);
      step();
    end

    // Counting: edge 5 counted above; 8 more plain edges, and the dump_start edge is the 10th.
    for (int n = 0; n < 8; n++) step();
    push_beat(0, 10, 0);
    push_beat(1, 0, 10);
    push_beat(2, 10, 0);
    push_beat(3, 0, 10);
    run_dump("count");

    // Saturation: 20 counted cycles of all-ones after a clear.
    clear    = 1'b1;
    cover_in = 4'b1111;
    step();
    clear = 1'b0;
    for (int n = 0; n < 20; n++) step();
    for (int i = 0; i < 4; i++) push_beat(i, 15, 0);
    run_dump("sat");

    // Assertion freeze: 3 counted cycles, fire on bit 1, then 5 frozen cycles.
    clear    = 1'b1;
    cover_in = 4'b0011;
    step();
    clear = 1'b0;
    for (int n = 0; n < 3; n++) step();
    assert_in = 2'b10;
    step();
    assert_in = 2'b00;
    check("fire_visible", {31'd0, assert_fired}, 32'd1);
    step();
    step();
    assert_in = 2'b11;
    step();
    assert_in = 2'b00;
    step();
    step();
    check("fired_sticky", {31'd0, assert_fired}, 32'd1);
    check("fired_index", {31'd0, assert_index}, 32'd1);
    push_beat(0, 3, 0);
    push_beat(1, 3, 0);
    push_beat(2, 0, 3);
    push_beat(3, 0, 3);
    run_dump("freeze");

    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_fired", {31'd0, assert_fired}, 32'd0);
    check("clear_index", {31'd0, assert_index}, 32'd0);

    // Backpressure: counted edges after clear are 2 plain plus the dump_start edge.
    cover_in = 4'b1000;
    step();
    step();
    push_beat(0, 0, 3);
    push_beat(1, 0, 3);
    push_beat(2, 0, 3);
    push_beat(3, 3, 0);
    dump_start = 1'b1;
    out_ready  = 1'b0;
    step();
    dump_start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (!busy) break;
      out_ready = !out_ready;
    end
    check("bp_idle", {31'd0, busy}, 32'd0);
    check("bp_drained", exp_q.size(), 32'd0);

    // Counters must not have moved during DUMP: only the new dump_start edge adds one.
    push_beat(0, 0, 4);
    push_beat(1, 0, 4);
    push_beat(2, 0, 4);
    push_beat(3, 4, 0);
    run_dump("frozen_dump");

    // Reset mid-dump while beat 2 is presented.
    push_beat(0, 0, 5);
    push_beat(1, 0, 5);
    push_beat(2, 0, 5);
    push_beat(3, 5, 0);
    dump_start = 1'b1;
    out_ready  = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    step();
    check("mid_index_before", {30'd0, out_index}, 32'd2);
    reset = 1'b1;
    #1;
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_meta", {31'd0, meta_reset_out}, 32'd1);
    check("mid_index", {30'd0, out_index}, 32'd0);
    check("mid_cnts", {24'd0, out_true_cnt, out_false_cnt}, 32'd0);
    exp_q.delete();
    step();
    reset = 1'b0;
    wait_idle("post_reset");

    // Collision: clear wins over dump_start, and that cycle is not counted.
    clear      = 1'b1;
    dump_start = 1'b1;
    step();
    clear      = 1'b0;
    dump_start = 1'b0;
    check("coll_busy", {31'd0, busy}, 32'd0);
    check("coll_valid", {31'd0, out_valid}, 32'd0);
    assert_in = 2'b11;
    step();
    assert_in = 2'b00;
    check("coll_index_low", {31'd0, assert_index}, 32'd0);
    check("coll_fired", {31'd0, assert_fired}, 32'd1);
    for (int i = 0; i < 4; i++) push_beat(i, 0, 0);
    run_dump("coll");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
